// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, an occupancy count, a synchronous flush and sticky error flags.
// Sits between a producer and a consumer that share one clock domain.
//
// Build option:
//   SYNC_FIFO_FWFT_EN  defined   -> first-word-fall-through read port: the
//                                   head word is shown combinationally on
//                                   rdata and rvalid = !empty.
//                      undefined -> registered read port: rdata is loaded
//                                   on an accepted read and rvalid pulses
//                                   for the following cycle (latency 1).
//
// Parameters:
//   DATA_W     data width in bits (>= 1)
//   DEPTH      number of entries (power of two, >= 2)
//   AF_THRESH  almost_full when count >= AF_THRESH
//   AE_THRESH  almost_empty when count <= AE_THRESH
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   clr           synchronous flush, overrides winc/rinc in the same cycle
//   winc, wdata   write request and data
//   rinc          read request
//   rdata, rvalid read data and its valid strobe
//   full, empty   count == DEPTH, count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     winc,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     rinc,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Thresholds sized to the count so every flag compare is width-matched.
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              rd_acc;
    logic              wr_acc;

    // Accept decisions. A flush cancels both requests outright. A write to a
    // full FIFO is still taken when a read frees a slot in the same cycle;
    // a read of an empty FIFO is never bypassed from the write port.
    always_comb begin
        rd_acc = 1'b0;
        wr_acc = 1'b0;
        if (!clr) begin
            rd_acc = rinc && !empty;
            wr_acc = winc && (!full || rd_acc);
        end
    end

    // Status flags are pure decodes of the registered count, so they move
    // one cycle after the edge that accepted the transfer.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Storage array. Deliberately not reset; the pointers alone define
    // which entries hold live data.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy. DEPTH is a power of two, so the pointers
    // wrap on their own. Count moves only when exactly one side transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_acc) begin
                rptr <= rptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags: any rejected request latches until flush or reset.
    // During a flush the requests are ignored, so they cannot set the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rinc && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN

    // Head word is always on the output; a read simply advances rptr.
    assign rdata  = mem[rptr];
    assign rvalid = !empty;

`else

    // Registered read port: the head word is captured on an accepted read
    // and presented with a one-cycle valid pulse. rdata keeps its last value
    // otherwise, including across a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (clr) begin
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_acc;
            if (rd_acc) begin
                rdata <= mem[rptr];
            end
        end
    end

`endif

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous single-clock FIFO. It is the next generation of the team's 8-bit, 16-deep FIFO.
- Adds configurable data width and depth, programmable almost-full and almost-empty flags, an occupancy count output, a synchronous flush, and sticky overflow/underflow error flags.
- Adds a registered read-data path with an optional first-word-fall-through (FWFT) build.
- Sits between producer and consumer blocks inside one clock domain.

Parameters:
- DATA_W, 8: data width in bits; must be ≥1.
- DEPTH, 16: number of entries; power of 2, ≥2.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH.
- CW (local), $clog2(DEPTH)+1: count width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush.
- winc  in  1  write request.
- wdata  in  DATA_W  write data.
- rinc  in  1  read request.
- rdata  out  DATA_W  read data.
- rvalid  out  1  rdata valid strobe.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wptr, rptr, count = 0.
  - rdata = 0, rvalid = 0, overflow = 0, underflow = 0.
  - Therefore empty = 1, almost_empty = 1, full = 0, almost_full = 0 (the last holds for AF_THRESH ≥ 1).
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all data immediately. The first write after release lands at entry 0.
- Accept rules, evaluated each cycle:
  - rd_acc = rinc && !empty.
  - wr_acc = winc && (!full || rd_acc). A write while full is accepted if a read is accepted in the same cycle.
- Pointers:
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - wr_acc: mem[wptr] ← wdata, wptr+1.
  - rd_acc: rptr+1.
- Count:
  - +1 on wr_acc only, −1 on rd_acc only, unchanged when both or neither occur.
  - Never exceeds DEPTH and never goes below 0.
- Flags:
  - full, empty, almost_full and almost_empty are combinational decodes of the registered count. They change in the cycle after the accepting edge.
- Read path (default build):
  - On rd_acc, rdata ← mem[rptr] at the clock edge, and rvalid = 1 for exactly that following cycle. Read latency is 1 cycle.
  - rdata holds its last value when no read is accepted.
- Simultaneous read/write:
  - When empty: the read is rejected and the write is accepted. count goes 0 → 1, underflow sets, and there is no read-during-empty bypass.
  - When full: both are accepted and count stays at DEPTH.
- Errors:
  - overflow sets on winc && !wr_acc.
  - underflow sets on rinc && !rd_acc.
  - Both are sticky until rst_n or clr.
- clr (synchronous):
  - Dominates winc and rinc in the same cycle; both are ignored.
  - Next state: pointers = 0, count = 0, rvalid = 0, overflow = 0, underflow = 0.
  - rdata holds its value.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined:
  - rdata = mem[rptr] combinationally, so the head word is visible whenever !empty.
  - rinc pops the head word; the next word appears after the edge.
  - rvalid = !empty, combinational.
  - Read latency is 0; all other rules are unchanged.
- Undefined: registered read path as described in Behaviour.

Test Plan:
- Reset then write 0xA5 (DATA_W=8), 1 cycle later rinc → empty drops after the write edge; rvalid = 1 and rdata = 0xA5 one cycle after the read edge; count sequence 0→1→0.
- Write 16 words 0x00..0x0F (DEPTH=16) → almost_full at count 14, full at 16. A 17th winc alone sets overflow, count stays 16, and readback yields 0x00..0x0F in order.
- Full FIFO with winc+rinc together for 20 cycles → count stays 16 and overflow stays 0. Data order is preserved across pointer wrap.
- Empty FIFO with rinc alone → underflow = 1, rvalid = 0, count = 0. Then winc+rinc together → count = 1 and rvalid = 0.
- With 5 entries held, pulse clr together with winc → count = 0, empty = 1, overflow/underflow = 0, and no data is written. Drop rst_n mid-burst → all outputs return to reset values asynchronously.
- FWFT build: write 0x3C → rdata = 0x3C and rvalid = 1 in the cycle after the write with no rinc. rinc → empty = 1 in the next cycle.
